ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain initiator for the FPGA fabric. It accepts bitstream words over a valid/ready stream, serializes them MSB-first onto the `ccff_head` of the tile configuration chain, and gates chain shifting with a clock enable. It also drives `IO_ISOL_N` so the IO tiles stay isolated until a load has completed cleanly. In verify mode it compares the bits leaving `ccff_tail` against the bits being shifted in, which gives a readback check when the same bitstream is sent a second time.

## Interface
- `CHAIN_LEN`, 64: total configuration bits in the chain (≥1).
- `WORD_W`, 8: input word width (≥1).
- `CNT_W`, `$clog2(CHAIN_LEN+1)`: derived width for bit counter and `mismatch_cnt`.

- `prog_clk`  in  1  sole clock; chain flops sample on rising edge.
- `prog_reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `verify`  in  1  captured with `start`; enables tail comparison for that load.
- `s_data`  in  WORD_W  bitstream word, MSB shifted first.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  word accepted when `s_valid & s_ready`.
- `ccff_head`  out  1  serial data into chain (registered).
- `ccff_clk_en`  out  1  chain clock-gate enable (registered); chain shifts only on edges where it is 1.
- `ccff_tail`  in  1  last chain flop output.
- `IO_ISOL_N`  out  1  0 = IOs isolated.
- `busy`  out  1  high from start acceptance until `done`.
- `done`  out  1  single-cycle pulse at end of load.
- `err`  out  1  verify failure; sticky until next accepted `start`.
- `mismatch_cnt`  out  CNT_W  tail mismatches in the current or last verify load.

## Operation
- FSM states: IDLE, FETCH, SHIFT, FINISH.
- **IDLE**
  - On `start`: `busy`=1, `IO_ISOL_N`=0, `bit_cnt`=0, `mismatch_cnt`=0, `err`=0; latch `verify`; go to FETCH.
- **FETCH**
  - `s_ready`=1 and `ccff_clk_en`=0.
  - On handshake, load `s_data` into the shift register, set `word_bits`=min(WORD_W, CHAIN_LEN−`bit_cnt`), and go to SHIFT.
- **SHIFT**
  - Each cycle: `ccff_clk_en`=1, `ccff_head`=shift-reg MSB, shift left, `bit_cnt`++.
  - After `word_bits` shifts: go to FINISH if `bit_cnt`==CHAIN_LEN, otherwise go to FETCH.
  - When `CHAIN_LEN` is not a multiple of `WORD_W`, the unused LSBs of the final word are discarded.
- **Verify**
  - In every cycle where the registered `ccff_clk_en`=1 and verify is latched, compare `ccff_tail` with `ccff_head`.
  - Increment `mismatch_cnt` on inequality. It cannot overflow, since it counts at most CHAIN_LEN.
- **FINISH** (one cycle)
  - `done`=1, `busy`=0.
  - `err`=1 if verify is latched and `mismatch_cnt`≠0.
  - `IO_ISOL_N`←1 only if `err`=0 (evaluate including any mismatch from the last shift).
  - Return to IDLE.
- **Ignored inputs**
  - `start` while busy is ignored.
  - `s_valid` outside FETCH is ignored.
- **Reset values:** `s_ready`=0, `ccff_head`=0, `ccff_clk_en`=0, `IO_ISOL_N`=0, `busy`=0, `done`=0, `err`=0, `mismatch_cnt`=0; state IDLE.
- **Reset mid-load:** takes effect at the next edge. The partial chain contents are abandoned and the fabric stays isolated.

## Timing
- `ccff_head` and `ccff_clk_en` are registered together. The chain captures `ccff_head` on the edge that ends a cycle in which `ccff_clk_en`=1.
- Throughput is WORD_W+1 cycles per word (one FETCH cycle plus WORD_W shift cycles) with `s_valid` held high. Stalls on `s_valid` only insert `ccff_clk_en`=0 cycles.
- First `ccff_clk_en`=1 occurs 2 cycles after `start` is sampled, given `s_valid` is already high.
- `done` is asserted the cycle after the last `ccff_clk_en`=1 cycle.
- `IO_ISOL_N` and `err` update on the edge that ends the FINISH cycle.
- Exactly CHAIN_LEN `ccff_clk_en`-high cycles occur per completed load.

## Structure
- Package `ccff_loader_pkg` holds:
  - the state enum (IDLE, FETCH, SHIFT, FINISH);
  - a `cnt_w(len)` function.
- Sub-module `ccff_word_serializer` contains the shift register, the per-word bit counter, and the registered `ccff_head`/`ccff_clk_en`. The top level owns the FSM, `bit_cnt`, the verify logic, and the status outputs.

## Test plan
All tests use CHAIN_LEN=20, WORD_W=8, with a 20-flop behavioral chain model.
- **Basic load.** `start`, verify=0, words 0xA5, 0x3C, 0xF0 with `s_valid` held high.
  - `ccff_head` bits: 10100101 00111100 1111.
  - `ccff_clk_en` bursts of 8, 8, 4 separated by single low cycles.
  - `done` pulses once; `IO_ISOL_N`=1; the chain model holds 0xA53CF.
- **Clean verify.** Repeat the same load with verify=1.
  - `mismatch_cnt`=0, `err`=0, `IO_ISOL_N`=1.
- **Failed verify.** Verify load with the second word sent as 0x3D.
  - `mismatch_cnt`=1, `err`=1, `IO_ISOL_N`=0.
- **Stalled input.** Drop `s_valid` for 5 cycles before word 2.
  - `ccff_clk_en`=0 and `ccff_head` steady during the gap.
  - Exactly 20 shifts in total; the chain model holds the correct value.
- **Reset mid-load.** Assert `prog_reset` on the 5th SHIFT cycle of word 2.
  - Next cycle: all outputs at reset values.
  - A subsequent full load produces a correct chain and `done`.
- **Start while busy.** Pulse `start` during SHIFT.
  - No effect: the bit sequence and `done` timing are identical to the basic load.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

    // Loader control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Width needed to count from 0 up to and including len.
    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: loads one bitstream word and presents it MSB-first
// on a registered head bit, with a registered clock enable that is high for
// exactly the number of bits requested at load time.
module ccff_word_serializer #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic [CNT_W-1:0]  load_bits,
    output logic              head,
    output logic              clk_en,
    output logic              last
);

    logic [WORD_W-1:0] sr;
    logic [CNT_W-1:0]  bits_left;

    // bits_left counts the bit currently on head, so 1 means this is the last one.
    assign last = clk_en && (bits_left == CNT_W'(1));

    // Shift register, remaining-bit counter and registered chain outputs.
    // NOTE: reset is synchronous and all state uses non-blocking assignments so
    // every flop updates from pre-edge values; head holds its value when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr        <= '0;
            bits_left <= '0;
            head      <= 1'b0;
            clk_en    <= 1'b0;
        end else if (load) begin
            head      <= data[WORD_W-1];
            sr        <= data << 1;
            bits_left <= load_bits;
            clk_en    <= 1'b1;
        end else if (bits_left > CNT_W'(1)) begin
            head      <= sr[WORD_W-1];
            sr        <= sr << 1;
            bits_left <= bits_left - CNT_W'(1);
            clk_en    <= 1'b1;
        end else begin
            bits_left <= '0;
            clk_en    <= 1'b0;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain initiator: streams bitstream words into the fabric
// configuration chain, optionally checks the tail against the new bits, and
// releases IO isolation only after a clean, complete load.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = cnt_w(CHAIN_LEN)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  mismatch_cnt
);

    state_t           state, state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] word_bits;
    logic             verify_q;
    logic             load;
    logic             word_last;
    logic             verify_fail;

    assign load        = (state == FETCH) && s_valid;
    assign verify_fail = verify_q && (mismatch_cnt != '0);

    ccff_word_serializer #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_serializer (
        .clk       (prog_clk),
        .reset     (prog_reset),
        .load      (load),
        .data      (s_data),
        .load_bits (word_bits),
        .head      (ccff_head),
        .clk_en    (ccff_clk_en),
        .last      (word_last)
    );

    // Bits to take from the next word: a full word, or only what the chain still needs.
    always_comb begin
        if (CHAIN_LEN - int'(bit_cnt) > WORD_W) begin
            word_bits = CNT_W'(WORD_W);
        end else begin
            word_bits = CNT_W'(CHAIN_LEN - int'(bit_cnt));
        end
    end

    // State register.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/status decode.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (word_last) begin
                    state_next = (bit_cnt == CNT_W'(CHAIN_LEN - 1)) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Load bookkeeping: bit count, tail comparison, and end-of-load status.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            bit_cnt      <= '0;
            mismatch_cnt <= '0;
            verify_q     <= 1'b0;
            err          <= 1'b0;
            IO_ISOL_N    <= 1'b0;
        end else if (state == IDLE && start) begin
            bit_cnt      <= '0;
            mismatch_cnt <= '0;
            verify_q     <= verify;
            err          <= 1'b0;
            IO_ISOL_N    <= 1'b0;
        end else begin
            if (ccff_clk_en) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (verify_q && (ccff_tail != ccff_head)) begin
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                end
            end
            if (state == FINISH) begin
                err       <= verify_fail;
                IO_ISOL_N <= !verify_fail;
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader with a 20-flop chain model. Stimulus pushes the
// expected head bits and end-of-load results into queues; a monitor pops and
// compares them whenever the DUT shifts a bit or pulses done.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 20;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    typedef struct {
        int                   mm;
        logic                 err;
        logic                 io;
        logic [CHAIN_LEN-1:0] chain;
        int                   lat;
    } result_t;

    logic              prog_clk = 1'b0;
    logic              prog_reset;
    logic              start;
    logic              verify;
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              ccff_head;
    logic              ccff_clk_en;
    logic              ccff_tail;
    logic              IO_ISOL_N;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  mismatch_cnt;

    logic [CHAIN_LEN-1:0] chain = '0;
    logic                 exp_bits[$];
    result_t              exp_res[$];
    int                   n_checks = 0;
    int                   n_pass   = 0;
    int                   cyc      = 0;
    int                   start_cyc = 0;
    int                   en_count;
    logic                 post_pending;
    result_t              cur;

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W),
        .CNT_W     (CNT_W)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .start        (start),
        .verify       (verify),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ccff_head    (ccff_head),
        .ccff_clk_en  (ccff_clk_en),
        .ccff_tail    (ccff_tail),
        .IO_ISOL_N    (IO_ISOL_N),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .mismatch_cnt (mismatch_cnt)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioral configuration chain and free-running cycle counter.
    assign ccff_tail = chain[CHAIN_LEN-1];
    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (ccff_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"},      s_ready,      0);
        check({tag, "_ccff_head"},    ccff_head,    0);
        check({tag, "_ccff_clk_en"},  ccff_clk_en,  0);
        check({tag, "_io_isol_n"},    IO_ISOL_N,    0);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_done"},         done,         0);
        check({tag, "_err"},          err,          0);
        check({tag, "_mismatch_cnt"}, mismatch_cnt, 0);
    endtask

    // Monitor: compares every shifted bit and every end-of-load result.
    initial begin
        en_count     = 0;
        post_pending = 1'b0;
        forever begin
            @(negedge prog_clk);
            if (prog_reset) begin
                en_count     = 0;
                post_pending = 1'b0;
            end else begin
                if (post_pending) begin
                    check("err_after_finish",  err,       cur.err);
                    check("isol_after_finish", IO_ISOL_N, cur.io);
                    post_pending = 1'b0;
                end
                if (ccff_clk_en) begin
                    check("shift_expected", exp_bits.size() > 0, 1);
                    if (exp_bits.size() > 0) check("head_bit", ccff_head, exp_bits.pop_front());
                    en_count++;
                end
                if (done) begin
                    check("done_expected", exp_res.size() > 0, 1);
                    if (exp_res.size() > 0) begin
                        cur = exp_res.pop_front();
                        check("mismatch_cnt_at_done", mismatch_cnt,    cur.mm);
                        check("shift_count",          en_count,        CHAIN_LEN);
                        check("chain_contents",       chain,           cur.chain);
                        check("done_latency",         cyc - start_cyc, cur.lat);
                        check("busy_low_at_done",     busy,            0);
                        post_pending = 1'b1;
                    end
                    en_count = 0;
                end
            end
        end
    end

    task automatic wait_handshake();
        for (int k = 0; k < 64; k++) begin
            @(negedge prog_clk);
            if (s_ready && s_valid) break;
        end
        check("s_ready_in_fetch",    s_ready,     1);
        check("clk_en_low_in_fetch", ccff_clk_en, 0);
        check("busy_in_fetch",       busy,        1);
        check("isol_during_load",    IO_ISOL_N,   0);
        @(posedge prog_clk); #1;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            @(negedge prog_clk);
            if (done) break;
        end
        check("done_seen", done, 1);
        @(posedge prog_clk); #1;
        @(posedge prog_clk); #1;
    endtask

    // One load of three words; optional input stall before word 2, reset
    // during word 2, or a stray start pulse while shifting word 1.
    task automatic run_load(input logic vfy, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input int stall, input bit kill,
                            input bit poke_start, input int exp_mm, input int exp_lat);
        logic [CHAIN_LEN-1:0] v;
        result_t              r;
        v = {w0, w1, w2[7:4]};
        for (int i = CHAIN_LEN - 1; i >= 0; i--) exp_bits.push_back(v[i]);
        if (!kill) begin
            r.mm    = exp_mm;
            r.err   = vfy && (exp_mm != 0);
            r.io    = !r.err;
            r.chain = v;
            r.lat   = exp_lat;
            exp_res.push_back(r);
        end
        start     = 1'b1;
        verify    = vfy;
        s_valid   = 1'b1;
        s_data    = w0;
        start_cyc = cyc;
        @(posedge prog_clk); #1;
        start  = 1'b0;
        verify = 1'b0;
        wait_handshake();
        s_data = w1;
        if (poke_start) begin
            start  = 1'b1;
            verify = 1'b1;
            @(posedge prog_clk); #1;
            start  = 1'b0;
            verify = 1'b0;
        end
        if (stall > 0) begin
            s_valid = 1'b0;
            repeat (8) @(posedge prog_clk);
            #1;
            repeat (stall) begin
                @(negedge prog_clk);
                check("clk_en_low_in_stall",  ccff_clk_en, 0);
                check("head_steady_in_stall", ccff_head,   w0[0]);
            end
            @(posedge prog_clk); #1;
            s_valid = 1'b1;
        end
        wait_handshake();
        if (kill) begin
            repeat (4) @(posedge prog_clk);
            #1;
            prog_reset = 1'b1;
            s_valid    = 1'b0;
            @(posedge prog_clk); #1;
            prog_reset = 1'b0;
            exp_bits.delete();
            exp_res.delete();
            @(negedge prog_clk);
            check_reset_values("after_kill");
            @(posedge prog_clk); #1;
            return;
        end
        s_data = w2;
        wait_handshake();
        s_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        prog_reset = 1'b1;
        start      = 1'b0;
        verify     = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        repeat (2) @(posedge prog_clk);
        @(negedge prog_clk);
        check_reset_values("reset");
        @(posedge prog_clk); #1;
        prog_reset = 1'b0;
        @(posedge prog_clk); #1;

        // Basic load, clean verify, failed verify (word 2 = 0x3D flips one bit).
        run_load(1'b0, 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b0, 0, 24);
        run_load(1'b1, 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b0, 0, 24);
        run_load(1'b1, 8'hA5, 8'h3D, 8'hF0, 0, 1'b0, 1'b0, 1, 24);
        // Five-cycle s_valid gap before word 2 adds five cycles.
        run_load(1'b0, 8'hA5, 8'h3C, 8'hF0, 5, 1'b0, 1'b0, 0, 29);
        // Verify load with mismatches, reset on the 5th shift of word 2, then a fresh load.
        run_load(1'b1, 8'h5A, 8'h3C, 8'hF0, 0, 1'b1, 1'b0, 0, 0);
        run_load(1'b0, 8'h5A, 8'hC3, 8'h0F, 0, 1'b0, 1'b0, 0, 24);
        // Stray start while shifting must not disturb the load.
        run_load(1'b0, 8'hA5, 8'h3C, 8'hF0, 0, 1'b0, 1'b1, 0, 24);

        repeat (3) @(posedge prog_clk);
        #1;
        check("bits_queue_drained",   exp_bits.size() == 0, 1);
        check("result_queue_drained", exp_res.size() == 0,  1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
